isqrt_share_arbiter: RTL

//  Shares one fixed-latency pipelined isqrt unit between n_req requesters.
//  - Round-robin grant, one argument issued per cycle.
//  - Each in-flight operation is tagged with its requester index.
//  - Each result is routed back to the requester that issued it.

---
 rtl/isqrt_share_arbiter_pkg.sv | 18 +
 rtl/isqrt_share_arbiter_rr.sv | 37 +++
 rtl/isqrt_share_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/isqrt_share_arbiter_pkg.sv
// Shared types for the isqrt sharing arbiter: requester-index width and the in-flight tag.
// Tags are sized for the largest supported requester count so one type serves every instance.
package isqrt_share_pkg;

    localparam int unsigned n_req_max = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned idx_w = idx_width(n_req_max);

    typedef struct packed {
        logic             vld;
        logic [idx_w-1:0] idx;
    } tag_t;

endpackage

// File: rtl/isqrt_share_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping to the lowest one.
// Output is one-hot (or zero) with the matching binary index.
module rr_arbiter
    import isqrt_share_pkg::*;
#(
    parameter int unsigned n = 3
) (
    input  logic [n-1:0]     req,
    input  logic [idx_w-1:0] ptr,
    output logic [n-1:0]     gnt,
    output logic [idx_w-1:0] gnt_idx
);

    logic hit;

    // First pass covers ptr..n-1, second pass the wrapped range 0..ptr-1.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        hit     = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            if (!hit && req[i] && (i >= 32'(ptr))) begin
                hit        = 1'b1;
                gnt[i]     = 1'b1;
                gnt_idx    = idx_w'(i);
            end
        end
        for (int unsigned i = 0; i < n; i++) begin
            if (!hit && req[i]) begin
                hit        = 1'b1;
                gnt[i]     = 1'b1;
                gnt_idx    = idx_w'(i);
            end
        end
    end

endmodule

// File: rtl/isqrt_share_arbiter.sv
// Shares one fixed-latency pipelined isqrt between n_req requesters: round-robin issue,
// a tag pipe matching the isqrt latency, and per-requester routing of returned results.
module isqrt_share_arbiter
    import isqrt_share_pkg::*;
#(
    parameter int unsigned n_req         = 3,
    parameter int unsigned width         = 32,
    parameter int unsigned isqrt_latency = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [n_req-1:0]       arg_vld,
    output logic [n_req-1:0]       arg_rdy,
    input  logic [n_req*width-1:0] arg,
    output logic [n_req-1:0]       res_vld,
    output logic [width-1:0]       res,
    output logic                   x_vld,
    output logic [width-1:0]       x,
    input  logic                   y_vld,
    input  logic [width-1:0]       y,
    output logic                   err
);

    logic [idx_w-1:0] ptr_q, ptr_d;
    logic [n_req-1:0] req_gated;
    logic [n_req-1:0] gnt;
    logic [idx_w-1:0] gnt_idx;

    tag_t             tag_in;
    tag_t             tag_q [isqrt_latency];
    tag_t             tag_out;

    logic [n_req-1:0] res_vld_q, res_vld_d;
    logic [width-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic             ret_hit;

    // Requests are masked during reset so nothing is granted or issued.
    assign req_gated = rst ? '0 : arg_vld;

    rr_arbiter #(
        .n (n_req)
    ) u_rr (
        .req     (req_gated),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign arg_rdy = gnt;
    assign x_vld   = |(arg_vld & gnt);

    always_comb begin
        x = '0;
        for (int unsigned i = 0; i < n_req; i++) begin
            if (gnt[i]) begin
                x = arg[i*width +: width];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (x_vld) begin
            ptr_d = (gnt_idx == idx_w'(n_req - 1)) ? '0 : gnt_idx + idx_w'(1);
        end
    end

    always_comb begin
        tag_in     = '0;
        tag_in.vld = x_vld;
        tag_in.idx = gnt_idx;
    end

    assign tag_out = tag_q[isqrt_latency-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < isqrt_latency; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int unsigned s = 1; s < isqrt_latency; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    // Results are only accepted when a live tag lines up with y_vld; any disagreement is sticky.
    always_comb begin
        ret_hit   = tag_out.vld & y_vld;
        res_vld_d = '0;
        for (int unsigned i = 0; i < n_req; i++) begin
            if (ret_hit && (tag_out.idx == idx_w'(i))) begin
                res_vld_d[i] = 1'b1;
            end
        end
        res_d = ret_hit ? y : res_q;
        err_d = err_q | (y_vld ^ tag_out.vld);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            res_vld_q <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            res_vld_q <= res_vld_d;
            res_q     <= res_d;
            err_q     <= err_d;
        end
    end

    assign res_vld = res_vld_q;
    assign res     = res_q;
    assign err     = err_q;

endmodule
